// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester, response and ALU-side signals
// for the shared-ALU arbiter.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_z;
  logic             rsp_zero;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_z;
  logic             alu_zero;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    input  alu_z, alu_zero,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    output rsp_z, rsp_zero,
    output alu_a, alu_b, alu_op,
    output busy, op_count
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    output alu_z, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    input  rsp_z, rsp_zero,
    input  alu_a, alu_b, alu_op,
    input  busy, op_count
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU
// between two requesters via an IDLE/ISSUE/RESP sequence.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] z_q;
  logic             zero_q;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;

  logic g0;
  logic g1;
  logic acc0;
  logic acc1;
  logic rdy0;
  logic rdy1;
  logic v0;
  logic v1;
  logic rsp_hs;

  // Round-robin grant: a tie goes to whoever did not win last time.
  always_comb begin
    g0 = bus.req0_valid & (~bus.req1_valid | last_grant);
    g1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
  end

  // Next state plus handshake outputs for the current state.
  always_comb begin
    nxt    = state;
    rdy0   = 1'b0;
    rdy1   = 1'b0;
    acc0   = 1'b0;
    acc1   = 1'b0;
    v0     = 1'b0;
    v1     = 1'b0;
    rsp_hs = 1'b0;
    unique case (state)
      IDLE: begin
        rdy0 = g0 & rst_n;
        rdy1 = g1 & rst_n;
        acc0 = rdy0;
        acc1 = rdy1;
        if (acc0 | acc1) nxt = ISSUE;
      end
      ISSUE: nxt = RESP;
      RESP: begin
        v0     = ~owner;
        v1     = owner;
        rsp_hs = owner ? bus.rsp1_ready
                       : bus.rsp0_ready;
        if (rsp_hs) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Operand capture, result capture and completion counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      z_q        <= '0;
      zero_q     <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      if (acc0 | acc1) begin
        a_q        <= acc1 ? bus.req1_a : bus.req0_a;
        b_q        <= acc1 ? bus.req1_b : bus.req0_b;
        op_q       <= acc1 ? bus.req1_op : bus.req0_op;
        owner      <= acc1;
        last_grant <= acc1;
      end
      if (state == ISSUE) begin
        z_q    <= bus.alu_z;
        zero_q <= bus.alu_zero;
      end
      if (rsp_hs && (cnt != '1)) cnt <= cnt + 1'b1;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.rsp0_valid = v0;
  assign bus.rsp1_valid = v1;
  assign bus.rsp_z      = z_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.busy       = (state != IDLE);
  assign bus.op_count   = cnt;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of the
// shared-ALU arbiter against a scoreboard model.
module tb_alu_share_arbiter;
  localparam int W = 32;
  localparam int C = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(W), .CNT_W(C)) bus ();

  alu_share_arbiter #(.WIDTH(W), .CNT_W(C)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  function automatic logic [W:0] alu_model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [2:0] op
  );
    logic [W-1:0] z;
    case (op)
      3'b000:  z = a & b;
      3'b001:  z = a | b;
      3'b010:  z = a + b;
      3'b110:  z = a - b;
      3'b111:  z = ($signed(a) < $signed(b)) ? 1 : 0;
      default: z = '0;
    endcase
    return {(z == '0), z};
  endfunction

  // Stand-in for the external combinational ALU.
  assign {bus.alu_zero, bus.alu_z} =
    alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic [2:0] op);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_a = a;
      bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a;
      bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  task automatic run_op(input int p,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [2:0] op);
    logic [W:0] e;
    e = alu_model(a, b, op);
    @(negedge clk);
    set_req(p, 1'b1, a, b, op);
    #1;
    chk("acc_ready",
        p ? bus.req1_ready : bus.req0_ready, 1);
    @(negedge clk);
    set_req(p, 1'b0, a, b, op);
    #1;
    chk("iss_busy", bus.busy, 1);
    chk("iss_norsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    chk("iss_alu_a", bus.alu_a, a);
    chk("iss_alu_op", bus.alu_op, op);
    @(negedge clk);
    #1;
    chk("rsp_valid", {bus.rsp1_valid, bus.rsp0_valid},
        (p != 0) ? 2'b10 : 2'b01);
    chk("rsp_z", bus.rsp_z, e[W-1:0]);
    chk("rsp_zero", bus.rsp_zero, e[W]);
    if (p == 0) bus.rsp0_ready = 1'b1;
    else        bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    exp_cnt++;
    #1;
    chk("done_busy", bus.busy, 0);
    chk("done_cnt", bus.op_count, exp_cnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010,
                          3'b110, 3'b111};

  initial begin
    int grants[$];
    logic [W+1:0] sbq[$];
    logic pend[2];
    logic [W-1:0] pa[2];
    logic [W-1:0] pb[2];
    logic [2:0] pop[2];
    logic [W+1:0] e;
    int issued;
    int done;

    rst_n = 1'b0;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt", bus.op_count, 0);
    chk("rst_rsp_z", bus.rsp_z, 0);
    chk("rst_zero", bus.rsp_zero, 0);
    chk("rst_alu", {bus.alu_a, bus.alu_b}, 0);
    chk("rst_op", bus.alu_op, 0);
    chk("rst_rv", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    chk("rst_rdy", {bus.req1_ready, bus.req0_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, then SUB/SLT on requester 1.
    run_op(0, 32'd5, 32'd3, 3'b010);
    run_op(1, 32'd7, 32'd7, 3'b110);
    run_op(1, -32'sd4, 32'd9, 3'b111);
    run_op(0, 32'hF0F0_1234, 32'h0FF0_00FF, 3'b000);
    run_op(1, 32'h8000_0000, 32'h1, 3'b001);

    // Contention: both valid continuously, alternating grants.
    do_reset();
    @(negedge clk);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (grants.size() < 4) begin
        set_req(0, 1'b1, 32'd1, 32'd2, 3'b010);
        set_req(1, 1'b1, 32'd9, 32'd4, 3'b110);
      end else begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      #1;
      chk("one_ready", bus.req0_ready & bus.req1_ready, 0);
      if (bus.req0_valid && bus.req0_ready) grants.push_back(0);
      if (bus.req1_valid && bus.req1_ready) grants.push_back(1);
      if (bus.rsp0_valid) begin
        exp_cnt++;
        chk("cont_z0", bus.rsp_z, 3);
      end
      if (bus.rsp1_valid) begin
        exp_cnt++;
        chk("cont_z1", bus.rsp_z, 5);
      end
      @(negedge clk);
    end
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    chk("cont_ngrant", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++)
      chk("cont_order", grants[i], i % 2);
    #1;
    chk("cont_cnt", bus.op_count, 4);
    chk("cont_cnt_m", bus.op_count, exp_cnt);

    // Backpressure on requester 0 while requester 1 waits.
    @(negedge clk);
    set_req(0, 1'b1, 32'd20, 32'd22, 3'b010);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    set_req(1, 1'b1, 32'd100, 32'd1, 3'b110);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_rv0", bus.rsp0_valid, 1);
      chk("bp_z", bus.rsp_z, 42);
      chk("bp_rdy1", bus.req1_ready, 0);
      chk("bp_busy", bus.busy, 1);
      chk("bp_alu_a", bus.alu_a, 20);
      @(negedge clk);
    end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    exp_cnt++;
    #1;
    chk("bp_rdy1_go", bus.req1_ready, 1);
    chk("bp_cnt", bus.op_count, exp_cnt);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    bus.rsp1_ready = 1'b1;
    #1;
    chk("bp_acc1", bus.alu_a, 100);
    @(negedge clk);
    #1;
    chk("bp_z1", bus.rsp_z, 99);
    chk("bp_rv1", bus.rsp1_valid, 1);
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
    exp_cnt++;
    #1;
    chk("bp_cnt2", bus.op_count, exp_cnt);

    // Asynchronous reset while in ISSUE.
    @(negedge clk);
    set_req(0, 1'b1, 32'd3, 32'd4, 3'b010);
    @(posedge clk);
    #2;
    chk("ar_busy_pre", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", bus.busy, 0);
    chk("ar_alu_a", bus.alu_a, 0);
    chk("ar_op", bus.alu_op, 0);
    chk("ar_z", bus.rsp_z, 0);
    chk("ar_cnt", bus.op_count, 0);
    chk("ar_rdy", {bus.req1_ready, bus.req0_ready}, 0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("ar_norsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    end
    exp_cnt = 0;
    rst_n = 1'b1;
    set_req(1, 1'b1, 32'd1, 32'd1, 3'b000);
    #1;
    chk("ar_tie0", bus.req0_ready, 1);
    chk("ar_tie1", bus.req1_ready, 0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("ar_z7", bus.rsp_z, 7);
    chk("ar_rv", {bus.rsp1_valid, bus.rsp0_valid}, 2'b01);
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    exp_cnt++;
    #1;
    chk("ar_cnt1", bus.op_count, exp_cnt);

    // Random regression against the scoreboard.
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    issued = 0;
    done = 0;
    for (int cyc = 0; cyc < 4000 && done < 200; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && issued < 200 &&
            $urandom_range(0, 2) != 0) begin
          pend[p] = 1'b1;
          pa[p] = $urandom;
          pb[p] = ($urandom_range(0, 3) == 0) ? pa[p]
                                              : $urandom;
          pop[p] = ops[$urandom_range(0, 4)];
          issued++;
        end
        set_req(p, pend[p], pa[p], pb[p], pop[p]);
      end
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_one_rdy", bus.req0_ready & bus.req1_ready, 0);
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? (bus.rsp0_valid && bus.rsp0_ready)
                     : (bus.rsp1_valid && bus.rsp1_ready)) begin
          if (sbq.size() == 0) begin
            chk("rnd_unexp", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("rnd_port", e[W+1], p);
            chk("rnd_z", bus.rsp_z, e[W-1:0]);
            chk("rnd_zero", bus.rsp_zero, e[W]);
          end
          done++;
          exp_cnt++;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? (bus.req0_valid && bus.req0_ready)
                     : (bus.req1_valid && bus.req1_ready)) begin
          sbq.push_back({p[0],
                         alu_model(pa[p], pb[p], pop[p])});
          pend[p] = 1'b0;
        end
      end
    end
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    chk("rnd_done", done, 200);
    chk("rnd_sb_empty", sbq.size(), 0);
    chk("rnd_cnt", bus.op_count, exp_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
